// File: rtl/button_pulse_gen.sv
// Two-button conditioner: synchroniser, debouncer and press FSM per button, plus an
// up/down conflict arbiter. Define AUTO_REPEAT_EN to build hold-to-repeat pulse generation.
module button_pulse_gen #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 10,
   parameter int REPEAT_PERIOD   = 5,
   parameter int CNT_W           = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic up_raw,
   input  logic down_raw,
   output logic up_pulse,
   output logic down_pulse,
   output logic up_level,
   output logic down_level
);

   // Index 0 is the UP button, index 1 is the DOWN button.
   localparam int NB = 2;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_RELEASED  = 2'd0,
      ST_HELD      = 2'd1,
      ST_REPEATING = 2'd2
   } state_t;
`else
   typedef enum logic [0:0] {
      ST_RELEASED = 1'b0,
      ST_HELD     = 1'b1
   } state_t;
`endif

   logic [NB-1:0]          raw;
   logic [SYNC_STAGES-1:0] sync_q    [NB];
   logic [SYNC_STAGES-1:0] sync_d    [NB];
   logic [CNT_W-1:0]       deb_cnt_q [NB];
   logic [CNT_W-1:0]       deb_cnt_d [NB];
   logic [NB-1:0]          s;
   logic [NB-1:0]          level_q;
   logic [NB-1:0]          level_d;
   logic [NB-1:0]          pulse_q;
   logic [NB-1:0]          pulse_d;
   logic [NB-1:0]          rise;
   logic [NB-1:0]          fall;
   logic [NB-1:0]          fire;
   logic                   conflict_now;
   logic                   conflict_hold;
   state_t                 state_q   [NB];
   state_t                 state_d   [NB];
`ifdef AUTO_REPEAT_EN
   logic [CNT_W-1:0]       rep_cnt_q [NB];
   logic [CNT_W-1:0]       rep_cnt_d [NB];
`endif

   assign raw = {down_raw, up_raw};

   // Synchroniser shift and debounce counter; level only moves after DEBOUNCE_CYCLES stable samples.
   always_comb begin
      for (int i = 0; i < NB; i++) begin
         sync_d[i]    = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
         s[i]         = sync_q[i][SYNC_STAGES-1];
         level_d[i]   = level_q[i];
         deb_cnt_d[i] = '0;
         if (s[i] != level_q[i]) begin
            if (deb_cnt_q[i] == DEB_LAST) begin
               level_d[i] = s[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
         end
      end
      rise          = level_d & ~level_q;
      fall          = ~level_d & level_q;
      conflict_now  = &level_d;
      // Including the previous levels means the edge on which one button lets go still
      // reloads the survivor, so its repeats resume a full period after the release.
      conflict_hold = conflict_now | (&level_q);
   end

   // Button FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NB; i++) begin
            state_q[i] <= ST_RELEASED;
         end
      end else begin
         for (int i = 0; i < NB; i++) begin
            state_q[i] <= state_d[i];
         end
      end
   end

   // Button FSM next state.
   always_comb begin
      for (int i = 0; i < NB; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            ST_RELEASED: begin
               if (rise[i]) state_d[i] = ST_HELD;
            end
            ST_HELD: begin
               if (fall[i]) begin
                  state_d[i] = ST_RELEASED;
`ifdef AUTO_REPEAT_EN
               end else if (!conflict_hold && (rep_cnt_q[i] == '0)) begin
                  state_d[i] = ST_REPEATING;
`endif
               end
            end
`ifdef AUTO_REPEAT_EN
            ST_REPEATING: begin
               if (fall[i]) state_d[i] = ST_RELEASED;
            end
`endif
            default: state_d[i] = ST_RELEASED;
         endcase
      end
   end

   // Button FSM outputs: press/repeat events, repeat counter and conflict-masked pulses.
   always_comb begin
      for (int i = 0; i < NB; i++) begin
         fire[i] = rise[i];
`ifdef AUTO_REPEAT_EN
         rep_cnt_d[i] = '0;
         if (level_d[i]) begin
            if (conflict_hold) begin
               rep_cnt_d[i] = PERIOD_LAST;
            end else if (rise[i]) begin
               rep_cnt_d[i] = DELAY_LAST;
            end else if (state_q[i] != ST_RELEASED) begin
               if (rep_cnt_q[i] == '0) begin
                  rep_cnt_d[i] = PERIOD_LAST;
                  fire[i]      = 1'b1;
               end else begin
                  rep_cnt_d[i] = rep_cnt_q[i] - 1'b1;
               end
            end
         end
`endif
         pulse_d[i] = fire[i] & ~conflict_now;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NB; i++) begin
            sync_q[i]    <= '0;
            deb_cnt_q[i] <= '0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q[i] <= '0;
`endif
         end
         level_q <= '0;
         pulse_q <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            sync_q[i]    <= sync_d[i];
            deb_cnt_q[i] <= deb_cnt_d[i];
`ifdef AUTO_REPEAT_EN
            rep_cnt_q[i] <= rep_cnt_d[i];
`endif
         end
         level_q <= level_d;
         pulse_q <= pulse_d;
      end
   end

   assign up_pulse   = pulse_q[0];
   assign down_pulse = pulse_q[1];
   assign up_level   = level_q[0];
   assign down_level = level_q[1];

endmodule

// File: doc/button_pulse_gen.md
# button_pulse_gen

Conditions the two raw game pushbuttons (up, down) into clean single-cycle command pulses for the game core, which consumes them as its UP/DOWN inputs. Per button, the block synchronises the raw input, debounces it and detects the press edge. Optional hold-to-repeat generation is included. An up/down conflict arbiter suppresses pulses while both buttons are held.

## Interface
- SYNC_STAGES, 2: synchroniser flops per button (≥2)
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a level change (≥1, ≤2^CNT_W−1)
- REPEAT_DELAY, 10: cycles from accepted press to first repeat pulse (≥2)
- REPEAT_PERIOD, 5: cycles between subsequent repeat pulses (≥2)
- CNT_W, 24: width of debounce and repeat counters

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- up_raw  in  1  raw UP pushbutton, asynchronous, active-high
- down_raw  in  1  raw DOWN pushbutton, asynchronous, active-high
- up_pulse  out  1  one-cycle UP command, registered
- down_pulse  out  1  one-cycle DOWN command, registered
- up_level  out  1  debounced UP level, registered
- down_level  out  1  debounced DOWN level, registered

## Operation
- Reset: all synchroniser flops, debounced levels, counters and pulse outputs go to 0; both button FSMs go to RELEASED.
- Synchroniser: the raw input passes through SYNC_STAGES flops. Its output is s.
- Debounce:
  - The counter clears whenever s == level.
  - When s != level, the counter increments.
  - On the edge where s != level and the counter equals DEBOUNCE_CYCLES−1, level takes s and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes level.
- Per-button FSM states: RELEASED, HELD, REPEATING.
  - RELEASED→HELD on level rise. This is the press event, and the repeat counter loads REPEAT_DELAY−1.
  - HELD→REPEATING when the repeat counter reaches 0. This is a repeat event, and the counter loads REPEAT_PERIOD−1.
  - In REPEATING, each time the counter reaches 0 a repeat event occurs and the counter reloads REPEAT_PERIOD−1.
  - Any state→RELEASED on level fall. No pulse is generated on release.
- Pulse: x_pulse is 1 for exactly one cycle per press or repeat event, unless conflict applies.
- Conflict: on any edge where both levels, after update, are 1, both pulse outputs are 0. Both repeat counters reload REPEAT_PERIOD−1 and keep doing so while both are held. Simultaneous press events on the same edge therefore produce no pulses.
- Reset mid-operation: a button still held after rst deasserts is treated as a new press. Its pulse appears after the normal sync+debounce latency.

## Timing
- Press latency: raw rises before edge 0. s is 1 after edge SYNC_STAGES. level and pulse are 1 after edge SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults). The pulse lasts one cycle.
- Release latency: the same, SYNC_STAGES+DEBOUNCE_CYCLES edges to level fall.
- First repeat pulse comes REPEAT_DELAY cycles after the press pulse. Further repeat pulses are spaced REPEAT_PERIOD cycles apart.
- Pulses are never adjacent: at least 2 cycles between pulses on the same output.
- level and pulse change only on clk edges, except for asynchronous clearing by rst.

## Configuration
- AUTO_REPEAT_EN defined: HELD/REPEATING behaviour and repeat counters are as described above.
- AUTO_REPEAT_EN undefined: the repeat counters and the REPEATING state are not built. Exactly one pulse is produced per accepted press, regardless of hold duration. Debounce and conflict rules are unchanged.

## Test plan
- Reset values: assert rst with up_raw=1 → all outputs 0 immediately, with no clk edge needed. Release rst with up_raw still 1 → up_pulse for one cycle at the 6th edge after deassertion.
- Clean press (defaults): up_raw 0→1 before edge 0 and held 3 cycles beyond debounce, then released → up_level=1 from edge 6, up_pulse=1 only in cycle 6–7. up_level falls 6 edges after release, with no down_pulse and no second up_pulse.
- Glitch rejection: down_raw high for 3 cycles, then low → down_level and down_pulse stay 0 throughout.
- Auto-repeat (AUTO_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5): down_raw held → down_pulse at edges 6, 16, 21, 26, … and stops within 6 edges of release.
- Auto-repeat off (AUTO_REPEAT_EN undefined): same stimulus → a single down_pulse at edge 6 only.
- Conflict: hold up_raw (pulse at 6), then assert down_raw at edge 8 → down_level rises at 14 with no down_pulse. There are no up_pulse repeats while both are held. After down_raw is released, up repeats resume REPEAT_PERIOD cycles after down_level falls.
